// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for an evolved 2x2-bit multiplier: counts matching product bits across bit-sliced lanes.
// Optional per-output mismatch counters are enabled by defining MUL4_SCORE_PER_OUTPUT_EN.
module mul4_fitness_scorer #(
  parameter int LANES     = 16,
  parameter int NUM_BEATS = 1,
  localparam int SCORE_W  = $clog2(4*LANES*NUM_BEATS+1)
`ifdef MUL4_SCORE_PER_OUTPUT_EN
  ,
  localparam int ERR_W    = $clog2(LANES*NUM_BEATS+1)
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   a1,
  input  logic [LANES-1:0]   a0,
  input  logic [LANES-1:0]   b1,
  input  logic [LANES-1:0]   b0,
  input  logic [LANES-1:0]   y3,
  input  logic [LANES-1:0]   y2,
  input  logic [LANES-1:0]   y1,
  input  logic [LANES-1:0]   y0,
  output logic               busy,
  output logic               score_valid,
  output logic [SCORE_W-1:0] score,
  output logic               perfect
`ifdef MUL4_SCORE_PER_OUTPUT_EN
  ,
  output logic [ERR_W-1:0]   err3,
  output logic [ERR_W-1:0]   err2,
  output logic [ERR_W-1:0]   err1,
  output logic [ERR_W-1:0]   err0
`endif
);

  localparam int CNT_W = $clog2(NUM_BEATS+1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(4*LANES*NUM_BEATS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   vld_p1_q;
  logic [3:0][LANES-1:0]  m_p1_q;
  logic [3:0][LANES-1:0]  m_d;
  logic [SCORE_W-1:0]     acc_q, acc_d;
  logic [SCORE_W-1:0]     beat_sum;
  logic [SCORE_W-1:0]     score_q;
  logic                   perfect_q;
  logic                   score_valid_q;
  logic                   hs;
  logic                   start_run;

  function automatic logic [SCORE_W-1:0] popcnt(input logic [LANES-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + SCORE_W'(v[i]);
    return c;
  endfunction

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign hs        = in_valid && in_ready;
  assign start_run = start && ((state_q == IDLE) || (state_q == DONE));

  // Golden 2x2 product per lane, compared bitwise against the candidate
  assign m_d[0] = ~(y0 ^ (a0 & b0));
  assign m_d[1] = ~(y1 ^ ((a1 & b0) ^ (a0 & b1)));
  assign m_d[2] = ~(y2 ^ (a1 & b1 & ~(a0 & b0)));
  assign m_d[3] = ~(y3 ^ (a1 & a0 & b1 & b0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(NUM_BEATS);
        end
      end
      RUN: begin
        if (hs) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(NUM_BEATS);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < 4; k++) beat_sum = beat_sum + popcnt(m_p1_q[k]);
    acc_d = acc_q;
    if (start_run)     acc_d = '0;
    else if (vld_p1_q) acc_d = acc_q + beat_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      vld_p1_q      <= 1'b0;
      m_p1_q        <= '0;
      acc_q         <= '0;
      score_valid_q <= 1'b0;
      score_q       <= '0;
      perfect_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // stage 1: match vectors captured on the handshake
      vld_p1_q <= hs;
      if (hs) m_p1_q <= m_d;
      // stage 2: popcount accumulated one cycle later
      acc_q    <= acc_d;
      // result: published on the edge leaving DONE
      score_valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        score_q   <= acc_q;
        perfect_q <= (acc_q == MAX_SCORE);
      end
    end
  end

  assign score_valid = score_valid_q;
  assign score       = score_q;
  assign perfect     = perfect_q;

`ifdef MUL4_SCORE_PER_OUTPUT_EN
  logic [ERR_W-1:0] err_acc_q [4];
  logic [ERR_W-1:0] err_q     [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        err_acc_q[k] <= '0;
        err_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (start_run)     err_acc_q[k] <= '0;
        else if (vld_p1_q) err_acc_q[k] <= err_acc_q[k] + ERR_W'(popcnt(~m_p1_q[k]));
        if (state_q == DONE) err_q[k] <= err_acc_q[k];
      end
    end
  end

  assign err3 = err_q[3];
  assign err2 = err_q[2];
  assign err1 = err_q[1];
  assign err0 = err_q[0];
`endif

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench for mul4_fitness_scorer: one-beat and two-beat instances checked against an arithmetic product model.
module tb_mul4_fitness_scorer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0, vld1 = 1'b0, start2 = 1'b0, vld2 = 1'b0;
  logic [15:0] a1 = '0, a0 = '0, b1 = '0, b0 = '0;
  logic [15:0] y3 = '0, y2 = '0, y1 = '0, y0 = '0;

  logic       rdy1, busy1, sv1, perf1;
  logic [6:0] score1;
  logic       rdy2, busy2, sv2, perf2;
  logic [7:0] score2;
`ifdef MUL4_SCORE_PER_OUTPUT_EN
  logic [4:0] e1_3, e1_2, e1_1, e1_0;
  logic [5:0] e2_3, e2_2, e2_1, e2_0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mul4_fitness_scorer #(.LANES(16), .NUM_BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(vld1), .in_ready(rdy1),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy1), .score_valid(sv1), .score(score1), .perfect(perf1)
`ifdef MUL4_SCORE_PER_OUTPUT_EN
    , .err3(e1_3), .err2(e1_2), .err1(e1_1), .err0(e1_0)
`endif
  );

  mul4_fitness_scorer #(.LANES(16), .NUM_BEATS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(vld2), .in_ready(rdy2),
    .a1(a1), .a0(a0), .b1(b1), .b0(b0), .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .busy(busy2), .score_valid(sv2), .score(score2), .perfect(perf2)
`ifdef MUL4_SCORE_PER_OUTPUT_EN
    , .err3(e2_3), .err2(e2_2), .err1(e2_1), .err0(e2_0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of lanes whose candidate bit k disagrees with the true product a*b.
  function automatic int ref_err(input int k);
    int e, av, bv, pr;
    logic [3:0] yv;
    e = 0;
    for (int i = 0; i < 16; i++) begin
      av = 2 * int'(a1[i]) + int'(a0[i]);
      bv = 2 * int'(b1[i]) + int'(b0[i]);
      pr = av * bv;
      yv = {y3[i], y2[i], y1[i], y0[i]};
      if (((pr >> k) & 1) != int'(yv[k])) e++;
    end
    return e;
  endfunction

  function automatic int ref_score();
    return 64 - (ref_err(0) + ref_err(1) + ref_err(2) + ref_err(3));
  endfunction

  task automatic rand_ops();
    a1 = 16'($urandom); a0 = 16'($urandom);
    b1 = 16'($urandom); b0 = 16'($urandom);
  endtask

  // Correct products, then a sparse random corruption mask per output.
  task automatic near_correct_y();
    int pr;
    for (int i = 0; i < 16; i++) begin
      pr = (2 * int'(a1[i]) + int'(a0[i])) * (2 * int'(b1[i]) + int'(b0[i]));
      y0[i] = pr[0]; y1[i] = pr[1]; y2[i] = pr[2]; y3[i] = pr[3];
    end
    y0 ^= 16'($urandom & $urandom & $urandom);
    y1 ^= 16'($urandom & $urandom & $urandom);
    y2 ^= 16'($urandom & $urandom & $urandom);
    y3 ^= 16'($urandom & $urandom & $urandom);
  endtask

  task automatic eval1(input string tag, input int exp);
    int k;
    start1 = 1'b1; tick(); start1 = 1'b0;
    check({tag, ":run_rdy"}, 32'(rdy1), 1);
    check({tag, ":run_busy"}, 32'(busy1), 1);
    vld1 = 1'b1; tick(); vld1 = 1'b0;
    check({tag, ":drain_rdy"}, 32'(rdy1), 0);
    k = 0;
    while (sv1 !== 1'b1 && k < 8) begin tick(); k++; end
    check({tag, ":latency"}, 32'(k), 2);
    check({tag, ":score"}, 32'(score1), 32'(exp));
    check({tag, ":perfect"}, 32'(perf1), 32'(exp == 64));
`ifdef MUL4_SCORE_PER_OUTPUT_EN
    check({tag, ":err3"}, 32'(e1_3), 32'(ref_err(3)));
    check({tag, ":err2"}, 32'(e1_2), 32'(ref_err(2)));
    check({tag, ":err1"}, 32'(e1_1), 32'(ref_err(1)));
    check({tag, ":err0"}, 32'(e1_0), 32'(ref_err(0)));
`endif
    tick();
    check({tag, ":sv_pulse"}, 32'(sv1), 0);
    check({tag, ":hold"}, 32'(score1), 32'(exp));
    check({tag, ":idle_busy"}, 32'(busy1), 0);
  endtask

  initial begin
    int k, cnt, exp2;

    tick(); tick();
    check("rst:rdy1", 32'(rdy1), 0);
    check("rst:busy1", 32'(busy1), 0);
    check("rst:sv1", 32'(sv1), 0);
    check("rst:score1", 32'(score1), 0);
    check("rst:perf1", 32'(perf1), 0);
    check("rst:score2", 32'(score2), 0);
    rst_n = 1'b1;
    tick();
    check("idle:rdy1", 32'(rdy1), 0);

    // 3*3 on every lane, correct candidate
    a1 = 16'hFFFF; a0 = 16'hFFFF; b1 = 16'hFFFF; b0 = 16'hFFFF;
    y3 = 16'hFFFF; y2 = 16'h0000; y1 = 16'h0000; y0 = 16'hFFFF;
    eval1("mul3x3", 64);
    y2 = 16'h00FF;
    eval1("y2err", 56);
`ifdef MUL4_SCORE_PER_OUTPUT_EN
    check("y2err:err2_const", 32'(e1_2), 8);
`endif
    a1 = '0; a0 = '0; b1 = '0; b0 = '0;
    y3 = 16'hFFFF; y2 = 16'hFFFF; y1 = 16'hFFFF; y0 = 16'hFFFF;
    eval1("allwrong", 0);

    for (int it = 0; it < 8; it++) begin
      rand_ops();
      if (it % 2 == 0) near_correct_y();
      else begin
        y3 = 16'($urandom); y2 = 16'($urandom); y1 = 16'($urandom); y0 = 16'($urandom);
      end
      eval1($sformatf("rand%0d", it), ref_score());
    end

    // start in the DONE cycle begins a new run immediately
    a1 = 16'hFFFF; a0 = 16'hFFFF; b1 = 16'hFFFF; b0 = 16'hFFFF;
    y3 = 16'hFFFF; y2 = 16'h0000; y1 = 16'h0000; y0 = 16'hFFFF;
    start1 = 1'b1; tick(); start1 = 1'b0;
    vld1 = 1'b1; tick(); vld1 = 1'b0;
    tick();
    check("sid:done_sv", 32'(sv1), 0);
    check("sid:done_busy", 32'(busy1), 0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("sid:sv", 32'(sv1), 1);
    check("sid:score", 32'(score1), 64);
    check("sid:new_run_rdy", 32'(rdy1), 1);
    y2 = 16'h00FF;
    vld1 = 1'b1; tick(); vld1 = 1'b0;
    tick(); tick();
    check("sid:sv2nd", 32'(sv1), 1);
    check("sid:score2nd", 32'(score1), 56);
    tick();

    // two beats of 60 with gaps, plus an ignored start mid-run
    y2 = 16'h0000; y1 = 16'h0000; y0 = 16'hFFF0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld2 = 1'b1; tick(); vld2 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("mb:gap%0d_rdy", g), 32'(rdy2), 1);
      check($sformatf("mb:gap%0d_busy", g), 32'(busy2), 1);
      start2 = (g == 0);
      tick();
      start2 = 1'b0;
    end
    y0 = 16'hFFFF; y1 = 16'h000F;
    vld2 = 1'b1; tick(); vld2 = 1'b0;
    check("mb:drain_rdy", 32'(rdy2), 0);
    k = 0;
    while (sv2 !== 1'b1 && k < 8) begin tick(); k++; end
    check("mb:latency", 32'(k), 2);
    check("mb:score", 32'(score2), 120);
    check("mb:perfect", 32'(perf2), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (sv2 === 1'b1) cnt++; end
    check("mb:single_sv", 32'(cnt), 0);

    // reset after the first of two beats
    rand_ops(); near_correct_y();
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld2 = 1'b1; tick(); vld2 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rr:score2", 32'(score2), 0);
    check("rr:busy2", 32'(busy2), 0);
    check("rr:rdy2", 32'(rdy2), 0);
    check("rr:sv2", 32'(sv2), 0);
    check("rr:score1", 32'(score1), 0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (sv2 === 1'b1) cnt++; end
    check("rr:no_sv", 32'(cnt), 0);
    check("rr:idle_busy", 32'(busy2), 0);

    exp2 = 0;
    rand_ops(); near_correct_y();
    exp2 += ref_score();
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld2 = 1'b1; tick();
    rand_ops(); near_correct_y();
    exp2 += ref_score();
    tick(); vld2 = 1'b0;
    k = 0;
    while (sv2 !== 1'b1 && k < 8) begin tick(); k++; end
    check("rr2:latency", 32'(k), 2);
    check("rr2:score", 32'(score2), 32'(exp2));
    check("rr2:perfect", 32'(perf2), 32'(exp2 == 128));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul4_fitness_scorer.md
# mul4_fitness_scorer

Sequential fitness scorer that sits directly downstream of an evolved 2x2-bit multiplier individual. Each individual processes bit-sliced vectors: every lane holds one test case, with operands {a1,a0} and {b1,b0} and candidate product {y3,y2,y1,y0}. The scorer consumes one or more beats of operands plus candidate outputs over a valid/ready handshake. For each beat it computes the golden product per lane and counts matching output bits. At the end of an evaluation it reports the accumulated score for tournament selection.

## Interface
- LANES, 16: test cases per beat (bit-slice width).
- NUM_BEATS, 1: beats per evaluation (>=1).
- SCORE_W, $clog2(4*LANES*NUM_BEATS+1): score width (derived; do not override).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  begin a new evaluation (single-cycle pulse).
- in_valid  input  1  beat present on a*/b*/y*.
- in_ready  output  1  scorer accepts a beat this cycle.
- a1, a0, b1, b0  input  LANES  operand bit-slices.
- y3, y2, y1, y0  input  LANES  candidate product bit-slices from the individual.
- busy  output  1  evaluation in progress (RUN or DRAIN).
- score_valid  output  1  one-cycle pulse: score is final.
- score  output  SCORE_W  number of matching output bits; holds until next start.
- perfect  output  1  score == 4*LANES*NUM_BEATS; valid with score.

## Operation
- Golden product per lane:
  - p0 = a0&b0
  - p1 = (a1&b0)^(a0&b1)
  - p2 = a1&b1&~(a0&b0)
  - p3 = a1&a0&b1&b0
- Match vector per output: m_k = ~(y_k ^ p_k), k = 0..3.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start. Entering RUN clears the accumulator and loads the beat counter to NUM_BEATS.
- RUN: in_ready=1. Each handshake (in_valid&&in_ready) registers m3..m0 (stage 1) and decrements the counter. The handshake that brings the counter to 0 moves to DRAIN. in_valid gaps stall without penalty.
- Stage 2: popcount(m3)+popcount(m2)+popcount(m1)+popcount(m0) is added to the accumulator in the cycle after each stage-1 load.
- DRAIN: in_ready=0. Waits one cycle for the final stage-2 add, then moves to DONE.
- DONE: score_valid=1 for one cycle. score and perfect are updated. The FSM then returns to IDLE.
- start while busy: ignored. start in the DONE cycle: accepted; next state is RUN.
- Arithmetic: the accumulator is SCORE_W bits wide and cannot overflow by construction (max 4*LANES*NUM_BEATS).
- Reset (asynchronous, any state):
  - FSM to IDLE.
  - in_ready=0, busy=0, score_valid=0, score=0, perfect=0.
  - Accumulator, counter and pipeline registers cleared.
  - An evaluation in progress is discarded and not reported.

## Timing
- A beat is accepted on the rising edge where in_valid&&in_ready.
- Final beat accepted at edge N: stage-1 load at N, accumulate at N+1, score_valid high during the cycle after edge N+2.
- Latency, final beat to score_valid: 2 cycles.
- score and perfect change only on the edge that raises score_valid.
- in_ready is a registered state decode with no combinational path from in_valid.
- Minimum evaluation period: NUM_BEATS+3 cycles, start through DONE.

## Configuration
- MUL4_SCORE_PER_OUTPUT_EN defined:
  - Adds outputs err3, err2, err1, err0, each $clog2(LANES*NUM_BEATS+1) bits.
  - Each counts mismatches on output bit k over the evaluation.
  - Cleared on start and reset; updated with score.
  - Invariant: score + err3+err2+err1+err0 == 4*LANES*NUM_BEATS.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

## Test plan
- Correct 3*3 product: LANES=16, NUM_BEATS=1, a1=a0=b1=b0=16'hFFFF, y3=16'hFFFF, y2=16'h0000, y1=16'h0000, y0=16'hFFFF -> score=64, perfect=1, score_valid exactly 2 cycles after the beat edge.
- Partial mismatch: same operands, y2=16'h00FF -> score=56, perfect=0; err2=8 with the macro defined.
- All outputs wrong: a*=b*=0, y3..y0=16'hFFFF -> score=0.
- Multi-beat with gaps: NUM_BEATS=2, in_valid low 3 cycles between beats, each beat scoring 60 -> single score_valid, score=120, in_ready low in DRAIN.
- Reset mid-run: assert rst_n=0 after the first of 2 beats -> outputs 0 immediately, no score_valid. A new start then scores cleanly from 0.
- start while busy: start pulse in RUN -> ignored; beat count and score unaffected. start in the DONE cycle -> new RUN begins on the next cycle.
